// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: handshake bundle between a byte producer, the TX FIFO and
// the UART transmitter.
//   enq_data/enq_valid/enq_ready : producer -> FIFO write handshake
//   deq_data/deq_valid/deq_ready : FIFO -> transmitter head handshake
//   count/full/empty             : FIFO occupancy status
// slave modport is the FIFO side; master is the surrounding logic.
interface uart_tx_fifo_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] enq_data;
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] deq_data;
    logic             deq_valid;
    logic             deq_ready;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    modport slave (
        input  enq_data, enq_valid, deq_ready,
        output enq_ready, deq_data, deq_valid, count, full, empty
    );

    modport master (
        output enq_data, enq_valid, deq_ready,
        input  enq_ready, deq_data, deq_valid, count, full, empty
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock first-word-fall-through FIFO feeding the UART
// transmitter.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (pointers only, storage untouched)
//   bus   : uart_tx_fifo_if.slave - enqueue side, dequeue side, status
// Status outputs depend only on the registered pointers; deq_data is a
// combinational read of the head slot.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_fifo_if.slave      bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;

    logic             w_full;
    logic             w_empty;
    logic             w_enq_fire;
    logic             w_deq_fire;

    // Extra MSB on each pointer distinguishes full from empty when the
    // index bits coincide.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) &&
                     (r_wptr[AW] != r_rptr[AW]);

    // No bypass in either direction: ready/valid come from pointers only.
    assign w_enq_fire = bus.enq_valid & ~w_full;
    assign w_deq_fire = bus.deq_ready & ~w_empty;

    assign bus.enq_ready = ~w_full;
    assign bus.deq_valid = ~w_empty;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.count     = r_wptr - r_rptr;
    assign bus.deq_data  = r_mem[r_rptr[AW-1:0]];

    // Pointer update; fires coinciding with reset are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_enq_fire) r_wptr <= r_wptr + PW'(1);
            if (w_deq_fire) r_rptr <= r_rptr + PW'(1);
        end
    end

    // Storage write; not reset.
    always_ff @(posedge clk) begin
        if (w_enq_fire && !reset) r_mem[r_wptr[AW-1:0]] <= bus.enq_data;
    end
endmodule
